// File: rtl/result_uart_tx_if.sv
// Result transmit port bundle: capture strobe/operands in, ASCII byte stream out.
// The master side drives the result and txready; the slave side is the transmitter.
interface result_uart_tx_if;
    logic       result_ready;
    logic [8:0] result;
    logic       sign;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic       done;

    modport master (
        output result_ready, result, sign, txready,
        input  txdata, txclk, busy, done
    );

    modport slave (
        input  result_ready, result, sign, txready,
        output txdata, txclk, busy, done
    );
endinterface

// File: rtl/result_uart_tx.sv
// Signed-magnitude result to ASCII decimal byte streamer (double-dabble, txready flow control).
// Optional CR/LF trailer when TX_CRLF_EN is defined.
module result_uart_tx #(
    parameter int RESULT_W    = 9,
    parameter int LZ_SUPPRESS = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic clk,
    input  logic reset,
    result_uart_tx_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_CONV, S_SIGN, S_HUND, S_TENS, S_ONES,
`ifdef TX_CRLF_EN
        S_CR, S_LF,
`endif
        S_GAP, S_DONE
    } state_t;

    localparam logic [7:0] GAP_LD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state_q, nxt_q;
    logic [8:0]  mag_q, shf_q;
    logic        neg_q;
    logic [11:0] bcd_q;
    logic [3:0]  cnt_q;
    logic [7:0]  gap_q;
    logic [7:0]  txdata_q;
    logic        busy_q;

    logic [11:0] bcd_d;
    logic [7:0]  cur_byte;
    logic        is_send;
    logic        accept;
    state_t      after_send;
    state_t      conv_exit;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Leading-zero suppression picks the first digit state; ones is always sent.
    function automatic state_t first_dig(input logic [11:0] b);
        if (LZ_SUPPRESS == 0)      return S_HUND;
        else if (b[11:8] != 4'd0)  return S_HUND;
        else if (b[7:4] != 4'd0)   return S_TENS;
        else                       return S_ONES;
    endfunction

    always_comb begin
        bcd_d = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        bcd_d = {bcd_d[10:0], shf_q[8]};
        conv_exit = (neg_q && mag_q != 9'd0) ? S_SIGN : first_dig(bcd_d);
        cur_byte   = 8'h00;
        is_send    = 1'b1;
        after_send = S_DONE;
        unique case (state_q)
            S_SIGN: begin
                cur_byte   = 8'h2D;
                after_send = first_dig(bcd_q);
            end
            S_HUND: begin
                cur_byte   = 8'h30 + {4'h0, bcd_q[11:8]};
                after_send = S_TENS;
            end
            S_TENS: begin
                cur_byte   = 8'h30 + {4'h0, bcd_q[7:4]};
                after_send = S_ONES;
            end
            S_ONES: begin
                cur_byte   = 8'h30 + {4'h0, bcd_q[3:0]};
`ifdef TX_CRLF_EN
                after_send = S_CR;
`else
                after_send = S_DONE;
`endif
            end
`ifdef TX_CRLF_EN
            S_CR: begin
                cur_byte   = 8'h0D;
                after_send = S_LF;
            end
            S_LF: begin
                cur_byte   = 8'h0A;
                after_send = S_DONE;
            end
`endif
            default: is_send = 1'b0;
        endcase
        accept = is_send && bus.txready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            nxt_q    <= S_IDLE;
            mag_q    <= '0;
            shf_q    <= '0;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            txdata_q <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.result_ready) begin
                        mag_q   <= bus.result;
                        shf_q   <= bus.result;
                        neg_q   <= bus.sign;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    shf_q <= {shf_q[7:0], 1'b0};
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd8) state_q <= conv_exit;
                end
                S_GAP: begin
                    if (gap_q == 8'd0) state_q <= nxt_q;
                    else               gap_q   <= gap_q - 8'd1;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (accept) begin
                        txdata_q <= cur_byte;
                        if (GAP_CYCLES == 0) begin
                            state_q <= after_send;
                        end else begin
                            gap_q   <= GAP_LD;
                            nxt_q   <= after_send;
                            state_q <= S_GAP;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.txclk  = accept;
    assign bus.txdata = accept ? cur_byte : txdata_q;
    assign bus.busy   = busy_q;
    assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: two instances (suppressing/no-gap and full-width/gapped).
// Expected byte streams are hand-computed; CR/LF appended when TX_CRLF_EN is defined.
module tb_result_uart_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    result_uart_tx_if b0();
    result_uart_tx_if b1();

    result_uart_tx #(.RESULT_W(9), .LZ_SUPPRESS(1), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );
    result_uart_tx #(.RESULT_W(9), .LZ_SUPPRESS(0), .GAP_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int st0, first0 = -1, last0, done0;
    int st1, first1 = -1;
    int b2b1 = 0;
    int stallclk = 0;
    logic prev1 = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (b0.result_ready && !b0.busy) begin st0 = ncyc; first0 = -1; end
        if (b0.txclk) begin
            q0.push_back(b0.txdata);
            if (first0 < 0) first0 = ncyc;
            last0 = ncyc;
        end
        if (b0.txclk && !b0.txready) stallclk++;
        if (b0.done) done0 = ncyc;
        if (b1.result_ready && !b1.busy) begin st1 = ncyc; first1 = -1; end
        if (b1.txclk) begin
            q1.push_back(b1.txdata);
            if (first1 < 0) first1 = ncyc;
        end
        if (b1.txclk && prev1) b2b1++;
        prev1 = b1.txclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input int u, input logic [8:0] v, input logic s);
        @(posedge clk); #1;
        if (u == 0) begin
            b0.result_ready = 1'b1; b0.result = v; b0.sign = s;
        end else begin
            b1.result_ready = 1'b1; b1.result = v; b1.sign = s;
        end
        @(posedge clk); #1;
        b0.result_ready = 1'b0;
        b1.result_ready = 1'b0;
    endtask

    task automatic wait_done(input int u, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            seen = (u == 0) ? b0.done : b1.done;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, (u == 0) ? b0.busy : b1.busy}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, (u == 0) ? b0.done : b1.done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, (u == 0) ? b0.busy : b1.busy}, 32'd0);
    endtask

    task automatic check_frame(input int u, input string tag, input logic [23:0] e, input int n);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        exp_q = {};
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(e[8*i +: 8]);
`ifdef TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
        got_q = (u == 0) ? q0 : q1;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    int nb;

    initial begin
        b0.result_ready = 1'b0; b0.result = '0; b0.sign = 1'b0; b0.txready = 1'b1;
        b1.result_ready = 1'b0; b1.result = '0; b1.sign = 1'b0; b1.txready = 1'b1;
`ifdef TX_CRLF_EN
        nb = 2;
`else
        nb = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txdata", {24'd0, b0.txdata}, 32'h00);
        chk("rst_txclk", {31'd0, b0.txclk}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_done", {31'd0, b0.done}, 32'd0);
        reset = 1'b0;

        q0.delete();
        strobe(0, 9'd123, 1'b0);
        chk("p123_busy", {31'd0, b0.busy}, 32'd1);
        wait_done(0, "p123");
        check_frame(0, "p123", 24'h313233, 3);
        chk("p123_lat", first0 - st0, 32'd10);
        chk("p123_b2b", last0 - first0, 3 + nb - 1);
        chk("p123_done_cyc", done0 - last0, 32'd1);

        q0.delete();
        strobe(0, 9'd7, 1'b1);
        wait_done(0, "n7");
        check_frame(0, "n7", 24'h002D37, 2);

        q0.delete();
        strobe(0, 9'd0, 1'b1);
        wait_done(0, "n0");
        check_frame(0, "n0", 24'h000030, 1);

        q0.delete();
        strobe(0, 9'd100, 1'b0);
        wait_done(0, "p100");
        check_frame(0, "p100", 24'h313030, 3);

        q0.delete();
        stallclk = 0;
        strobe(0, 9'd40, 1'b0);
        repeat (10) @(posedge clk);
        #1 b0.txready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_busy", {31'd0, b0.busy}, 32'd1);
        chk("stall_count", q0.size(), 32'd1);
        b0.txready = 1'b1;
        wait_done(0, "stall");
        check_frame(0, "stall", 24'h003430, 2);
        chk("stall_noclk", stallclk, 32'd0);

        q0.delete();
        strobe(0, 9'd123, 1'b0);
        repeat (3) @(posedge clk);
        #1 b0.result_ready = 1'b1; b0.result = 9'd99; b0.sign = 1'b1;
        @(posedge clk);
        #1 b0.result_ready = 1'b0;
        wait_done(0, "ign");
        check_frame(0, "ign", 24'h313233, 3);

        strobe(0, 9'd123, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_txclk", {31'd0, b0.txclk}, 32'd0);
        chk("mid_rst_busy", {31'd0, b0.busy}, 32'd0);
        reset = 1'b0;
        q0.delete();
        strobe(0, 9'd5, 1'b0);
        wait_done(0, "post_rst");
        check_frame(0, "post_rst", 24'h000035, 1);

        q1.delete();
        b2b1 = 0;
        strobe(1, 9'd511, 1'b0);
        wait_done(1, "f511");
        check_frame(1, "f511", 24'h353131, 3);
        chk("f511_lat", first1 - st1, 32'd10);

        q1.delete();
        strobe(1, 9'd5, 1'b0);
        wait_done(1, "f005");
        check_frame(1, "f005", 24'h303035, 3);
        chk("gap_b2b", b2b1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
